// File: rtl/nios_status_pkg.sv
// Shared definitions for the Nios II status input port.
//   - Register offsets of the Avalon-MM slave.
//   - Edge-capture type encodings.
//   - edge_hit(): edge detector for one bit, for the selected edge type.
package nios_status_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when cur/prev form an edge of the requested kind.
  // An unknown encoding falls back to rising-edge capture.
  function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
    logic hit;
    hit = 1'b0;
    case (edge_type)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      EDGE_ANY:  hit = cur ^ prev;
      default:   hit = cur & ~prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/status_debounce.sv
// Single-bit input conditioner: two-stage synchronizer followed by a
// stability counter. The output changes only after the synchronized input
// has differed from it for DEBOUNCE_CYCLES consecutive clocks.
// DEBOUNCE_CYCLES = 0 bypasses the counter and leaves one registered stage.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   din     in  raw input, asynchronous to clk
//   dout    out debounced, registered value
module status_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_r;
  logic       deb_r;

  // Two-flop synchronizer; sync_r[1] is din delayed by 2 clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], din};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      // No filtering: accept the synchronized value one clock later.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_r <= RESET_VALUE;
        end else begin
          deb_r <= sync_r[1];
        end
      end
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_r;

      // Count consecutive clocks of disagreement; any agreement restarts
      // the count, so a glitch shorter than DEBOUNCE_CYCLES is dropped.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_r <= '0;
          deb_r <= RESET_VALUE;
        end else if (sync_r[1] == deb_r) begin
          cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
          cnt_r <= '0;
          deb_r <= sync_r[1];
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  endgenerate

  assign dout = deb_r;

endmodule

// File: rtl/nios_system_status_in.sv
// Avalon-MM slave input port for Nios II: per-bit synchronizer and
// debouncer, edge capture, and a maskable level interrupt.
// Register map (zero wait states, reads have no side effects):
//   0 DATA    debounced inputs, read-only
//   1 rsvd    reads 0
//   2 IRQMASK read/write
//   3 EDGECAP read / write-1-to-clear
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata           slave bus inputs
//   in_port [WIDTH]              external status lines (asynchronous)
//   readdata [32]                combinational read mux
//   irq                          registered level interrupt
module nios_system_status_in
  import nios_status_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 1000,
  parameter int               EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] deb_d_r;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] edge_capture_r;
  logic             irq_r;
  logic             wr_en_s;
  logic             unused_wdata_s;

  assign wr_en_s        = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      status_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VALUE     (RESET_VALUE[i])
      ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port[i]),
        .dout    (deb_s[i])
      );

      assign edge_s[i] = edge_hit(EDGE_TYPE, deb_s[i], deb_d_r[i]);
    end
  endgenerate

  // Delayed copy of the debounced data; resets to the same value as the
  // debouncer so that reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d_r <= RESET_VALUE;
    end else begin
      deb_d_r <= deb_s;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_r <= '0;
    end else if (wr_en_s && (address == ADDR_IRQMASK)) begin
      irq_mask_r <= writedata[WIDTH-1:0];
    end else begin
      irq_mask_r <= irq_mask_r;
    end
  end

  // Bits requested for clearing by a write-1 to EDGECAP.
  always_comb begin
    clr_s = '0;
    if (wr_en_s && (address == ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // Edge capture: clear is applied first, so a new edge in the same cycle
  // keeps its bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture_r <= '0;
    end else begin
      edge_capture_r <= (edge_capture_r & ~clr_s) | edge_s;
    end
  end

  // Registered level interrupt, one clock behind EDGECAP/IRQMASK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |(edge_capture_r & irq_mask_r);
    end
  end

  assign irq = irq_r;

  // Read mux; unused upper bits and the reserved offset read as zero.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = deb_s;
      ADDR_RSVD:    readdata            = 32'h0000_0000;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_r;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_capture_r;
      default:      readdata            = 32'h0000_0000;
    endcase
  end

endmodule
